bcd_conv_arb: RTL

BCD_CONV_ARB -- requirements
Module: bcd_conv_arb

---
 rtl/bcd_conv_arb.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bcd_conv_arb.sv
// Two-requester round-robin front end for an iterative double-dabble binary-to-BCD converter.
// Optional macro BCD_CONV_ARB_BLANK_EN: blank leading zero digits (bcd3..bcd1) as 4'hF.
module bcd_conv_arb #(
  parameter int unsigned W   = 14,
  parameter int unsigned SAT = 9999
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] bin0,
  input  logic [W-1:0] bin1,
  output logic [1:0]   ack,
  output logic         busy,
  output logic         out_valid,
  output logic         out_id,
  output logic [3:0]   bcd3,
  output logic [3:0]   bcd2,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0
);

  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam int unsigned BCD_W = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       sr;
  logic [BCD_W-1:0]   bcd;
  logic               last;
  logic               id;

  logic               grant_en;
  logic               grant_id;
  logic [W-1:0]       sel;
  logic [W-1:0]       sel_sat;
  logic [BCD_W-1:0]   adj;
  logic [3:0]         dig3, dig2, dig1, dig0;

  // Next state, round-robin grant, operand clamp, add-3 correction and digit formatting
  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    grant_id   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          grant_en   = 1'b1;
          state_next = SHIFT;
          grant_id   = (req == 2'b11) ? ~last : req[1];
        end
      end
      SHIFT:   if (cnt == CNT_W'(W - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    sel     = grant_id ? bin1 : bin0;
    sel_sat = (32'(sel) > SAT) ? W'(SAT) : sel;

    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    dig3 = bcd[15:12];
    dig2 = bcd[11:8];
    dig1 = bcd[7:4];
    dig0 = bcd[3:0];
`ifdef BCD_CONV_ARB_BLANK_EN
    if (bcd[15:12] == 4'd0) begin
      dig3 = 4'hF;
      if (bcd[11:8] == 4'd0) begin
        dig2 = 4'hF;
        if (bcd[7:4] == 4'd0) dig1 = 4'hF;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      bcd       <= '0;
      last      <= 1'b1;
      id        <= 1'b0;
      ack       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      bcd3      <= '0;
      bcd2      <= '0;
      bcd1      <= '0;
      bcd0      <= '0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != IDLE);
      ack       <= '0;
      out_valid <= 1'b0;
      if (grant_en) begin
        sr   <= sel_sat;
        bcd  <= '0;
        cnt  <= '0;
        id   <= grant_id;
        last <= grant_id;
        ack  <= grant_id ? 2'b10 : 2'b01;
      end
      if (state == SHIFT) begin
        // Correct columns first, then shift the combined BCD:binary register left
        {bcd, sr} <= {adj[BCD_W-2:0], sr, 1'b0};
        cnt       <= cnt + CNT_W'(1);
      end
      if (state == DONE) begin
        bcd3      <= dig3;
        bcd2      <= dig2;
        bcd1      <= dig1;
        bcd0      <= dig0;
        out_id    <= id;
        out_valid <= 1'b1;
      end
    end
  end

endmodule
